// File: rtl/pc_flag_control.sv
// Z/N/V flag register and program counter sequencer. Captures ALU flags per opcode,
// resolves B/BR against bypassed flags and steps the PC through RUN and HALT.
module pc_flag_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  alu_op,
    input  logic        alu_valid,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        br_valid,
    input  logic        br_reg,
    input  logic [2:0]  br_cond,
    input  logic [8:0]  br_imm,
    input  logic [15:0] br_rs,
    input  logic        hlt,
    input  logic        stall,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        taken,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic        halted
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    function automatic logic cond_true(input logic [2:0] ccc, input logic z,
                                       input logic n, input logic v);
        logic res;
        case (ccc)
            3'b000:  res = !z;
            3'b001:  res = z;
            3'b010:  res = !z && !n;
            3'b011:  res = n;
            3'b100:  res = z || (!z && !n);
            3'b101:  res = n || z;
            3'b110:  res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Word offset becomes a byte offset; the sum wraps modulo 2^16.
    function automatic logic [15:0] b_target(input logic [15:0] base, input logic [8:0] imm);
        logic signed [15:0] offset;
        offset = $signed({{6{imm[8]}}, imm, 1'b0});
        return base + $unsigned(offset);
    endfunction

    function automatic logic [15:0] br_target(input logic [15:0] rs);
        return rs & 16'hFFFE;
    endfunction

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [15:0] pc_next;
    logic [15:0] target;
    logic        in_run;
    logic        wr_znv;
    logic        wr_z;
    logic        eff_z;
    logic        eff_n;
    logic        eff_v;
    logic        flag_we;

    assign in_run   = (state == RUN);
    assign pc_plus2 = pc + 16'd2;
    assign halted   = (state == HALT);

    assign wr_znv = (alu_op == OP_ADD) || (alu_op == OP_SUB);
    assign wr_z   = wr_znv || (alu_op == OP_XOR) || (alu_op == OP_SLL) ||
                    (alu_op == OP_SRA) || (alu_op == OP_ROR);

    // Branches see this cycle's ALU flags before they reach the register.
    assign eff_z = (alu_valid && wr_z)   ? alu_z : flag_z;
    assign eff_n = (alu_valid && wr_znv) ? alu_n : flag_n;
    assign eff_v = (alu_valid && wr_znv) ? alu_v : flag_v;

    assign flag_we = alu_valid && in_run;

    assign taken  = br_valid && !stall && !hlt && in_run &&
                    cond_true(br_cond, eff_z, eff_n, eff_v);
    assign target = br_reg ? br_target(br_rs) : b_target(pc_plus2, br_imm);

    always_comb begin
        pc_next    = pc;
        state_next = state;
        if (in_run) begin
            if (stall) begin
                pc_next = pc;
            end else if (hlt) begin
                state_next = HALT;
            end else if (taken) begin
                pc_next = target;
            end else begin
                pc_next = pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (flag_we) begin
            if (wr_z) begin
                flag_z <= alu_z;
            end
            if (wr_znv) begin
                flag_n <= alu_n;
                flag_v <= alu_v;
            end
        end
    end

endmodule
